// File: rtl/ysyx_ifq.sv
// Instruction fetch queue: circular FIFO of {pc, inst, spec} between fetch and decode.
// Optional same-cycle pass-through when empty is enabled by defining YSYX_IFQ_BYPASS_EN.
module ysyx_ifq #(
  parameter int DATA_W    = 32,
  parameter int DEPTH_LEN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prev_valid,
  output logic                 ready_o,
  input  logic [DATA_W-1:0]    inst_i,
  input  logic [DATA_W-1:0]    pc_i,
  input  logic                 speculation_i,
  input  logic                 flush_i,
  input  logic                 good_speculation_i,
  output logic                 valid_o,
  input  logic                 next_ready,
  output logic [DATA_W-1:0]    inst_o,
  output logic [DATA_W-1:0]    pc_o,
  output logic                 spec_o,
  output logic [DEPTH_LEN:0]   count_o
);
  localparam int DEPTH = 1 << DEPTH_LEN;
  localparam int PW    = DEPTH_LEN + 1;

  logic [DATA_W-1:0] pc_q   [DEPTH];
  logic [DATA_W-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]  spec_q, spec_d;
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d, nonspec_q, nonspec_d;

  logic [DEPTH_LEN-1:0] ridx, widx;
  logic          empty, full, head_spec;
  logic          q_valid, q_deq, enq, wr_en, ns_deq;
  logic          byp_act, byp_pass;
  logic [PW-1:0] ns_post, count_d;

  assign ridx      = rptr_q[DEPTH_LEN-1:0];
  assign widx      = wptr_q[DEPTH_LEN-1:0];
  assign empty     = (rptr_q == wptr_q);
  assign full      = (ridx == widx) && (rptr_q[DEPTH_LEN] != wptr_q[DEPTH_LEN]);
  assign head_spec = spec_q[ridx];
  assign ready_o   = !full;
  assign count_o   = wptr_q - rptr_q;

  // A speculative head is hidden while its flush is in flight.
  assign q_valid = !empty && !(flush_i && head_spec);
  assign q_deq   = q_valid && next_ready;
  assign enq     = prev_valid && ready_o && !flush_i;

`ifdef YSYX_IFQ_BYPASS_EN
  assign byp_act  = empty && !flush_i && prev_valid;
  assign byp_pass = byp_act && next_ready;
  assign valid_o  = q_valid || byp_act;
  assign inst_o   = byp_act ? inst_i : inst_q[ridx];
  assign pc_o     = byp_act ? pc_i   : pc_q[ridx];
  assign spec_o   = byp_act ? (speculation_i && !good_speculation_i) : (!empty && head_spec);
`else
  assign byp_act  = 1'b0;
  assign byp_pass = 1'b0;
  assign valid_o  = q_valid;
  assign inst_o   = inst_q[ridx];
  assign pc_o     = pc_q[ridx];
  assign spec_o   = !empty && head_spec;
`endif

  assign wr_en  = enq && !byp_pass;
  assign ns_deq = q_deq && !head_spec;

  always_comb begin
    rptr_d    = rptr_q + PW'(q_deq);
    ns_post   = nonspec_q - PW'(ns_deq);
    wptr_d    = wptr_q;
    nonspec_d = ns_post;
    spec_d    = spec_q;
    count_d   = '0;
    if (flush_i) begin
      // Speculative entries are the contiguous tail, so the survivors are exactly
      // the oldest non-speculative ones.
      wptr_d    = rptr_d + ns_post;
      nonspec_d = ns_post;
      spec_d    = '0;
    end else begin
      wptr_d = wptr_q + PW'(wr_en);
      if (wr_en) begin
        spec_d[widx] = speculation_i;
        if (!speculation_i) nonspec_d = ns_post + PW'(1);
      end
      if (good_speculation_i) begin
        count_d   = wptr_d - rptr_d;
        spec_d    = '0;
        nonspec_d = count_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      nonspec_q <= '0;
      spec_q    <= '0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      nonspec_q <= nonspec_d;
      spec_q    <= spec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      pc_q[widx]   <= pc_i;
      inst_q[widx] <= inst_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(wr_en && full));
      assert (!(q_deq && empty));
    end
  end

endmodule

// File: tb/tb_ysyx_ifq.sv
// Directed bench for ysyx_ifq with a queue-based reference of the buffered entries.
module tb_ysyx_ifq;
  logic        clk = 1'b0;
  logic        rst;
  logic        prev_valid, ready_o, speculation_i, flush_i, good_speculation_i;
  logic        valid_o, next_ready, spec_o;
  logic [31:0] inst_i, pc_i, inst_o, pc_o;
  logic [2:0]  count_o;

  ysyx_ifq #(.DATA_W(32), .DEPTH_LEN(2)) dut (
    .clk(clk), .rst(rst), .prev_valid(prev_valid), .ready_o(ready_o),
    .inst_i(inst_i), .pc_i(pc_i), .speculation_i(speculation_i),
    .flush_i(flush_i), .good_speculation_i(good_speculation_i),
    .valid_o(valid_o), .next_ready(next_ready), .inst_o(inst_o),
    .pc_o(pc_o), .spec_o(spec_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        spec;
  } ent_t;

  ent_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] mk_inst(input logic [31:0] pc);
    return {pc[15:0], 16'h0013};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs against the reference, update it.
  task automatic step(input logic r, input logic pv, input logic [31:0] pc, input logic sp,
                      input logic nr, input logic fl, input logic gd);
    logic exp_valid, do_enq, do_deq;
    ent_t keep[$];
    @(negedge clk);
    rst = r; prev_valid = pv; pc_i = pc; inst_i = mk_inst(pc);
    speculation_i = sp; next_ready = nr; flush_i = fl; good_speculation_i = gd;
    #1;
    if (r) begin
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && !(fl && q[0].spec);
      do_deq    = exp_valid && nr;
      do_enq    = pv && (q.size() < 4) && !fl;
      chk("valid_o", 32'(valid_o), 32'(exp_valid));
      chk("ready_o", 32'(ready_o), 32'(q.size() < 4));
      chk("count_o", 32'(count_o), q.size());
      if (q.size() > 0) begin
        chk("head_pc", pc_o, q[0].pc);
        chk("spec_o", 32'(spec_o), 32'(q[0].spec));
        if (do_deq) chk("deq_inst", inst_o, q[0].inst);
      end else begin
        chk("spec_o_empty", 32'(spec_o), 32'd0);
      end
      if (do_deq) void'(q.pop_front());
      if (fl) begin
        foreach (q[i]) if (!q[i].spec) keep.push_back(q[i]);
        q = keep;
      end else begin
        if (do_enq) q.push_back('{pc: pc, inst: mk_inst(pc), spec: sp});
        if (gd) foreach (q[i]) q[i].spec = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input logic nr);
    step(1'b0, 1'b0, 32'h0, 1'b0, nr, 1'b0, 1'b0);
  endtask

  task automatic push(input logic [31:0] pc, input logic sp, input logic nr);
    step(1'b0, 1'b1, pc, sp, nr, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; prev_valid = 0; pc_i = 0; inst_i = 0; speculation_i = 0;
    next_ready = 0; flush_i = 0; good_speculation_i = 0;
    step(1'b1, 0, 0, 0, 0, 0, 0);
    step(1'b1, 0, 0, 0, 0, 0, 0);
    idle(1'b0);

    // Fill to capacity, then a refused fifth enqueue.
    for (int i = 0; i < 4; i++) push(32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0);
    #1;
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(ready_o), 32'd0);
    push(32'h8000_0010, 1'b0, 1'b0);
    #1;
    chk("refused_count", 32'(count_o), 32'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) idle(1'b1);
    idle(1'b1);

    // Steady stream across a pointer wrap.
    for (int i = 0; i < 10; i++) push(32'h8000_0100 + 32'(4 * i), 1'b0, 1'b1);
    #1;
    chk("stream_count", 32'(count_o), 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Flush with a dequeuing non-spec head; spec tail discarded.
    push(32'h0000_00a0, 1'b0, 1'b0);
    push(32'h0000_00b0, 1'b1, 1'b0);
    push(32'h0000_00c0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h0000_00e0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    chk("flush_count", 32'(count_o), 32'd0);
    push(32'h0000_00d0, 1'b0, 1'b0);
    #1;
    chk("d_head", pc_o, 32'h0000_00d0);
    idle(1'b1);
    idle(1'b1);

    // Flush beats good speculation in the same cycle.
    push(32'h0000_01a0, 1'b0, 1'b0);
    push(32'h0000_01b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("fg_count", 32'(count_o), 32'd1);
    chk("fg_spec", 32'(spec_o), 32'd0);
    chk("fg_head", pc_o, 32'h0000_01a0);
    idle(1'b1);
    idle(1'b1);

    // Confirmed entry survives a later flush.
    push(32'h0000_02b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("good_count", 32'(count_o), 32'd1);
    chk("good_spec", 32'(spec_o), 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Reset with entries queued.
    for (int i = 0; i < 3; i++) push(32'h0000_0300 + 32'(4 * i), 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0; prev_valid = 1'b0;
    #1;
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    idle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
